mult_seq_ctrl: RTL and testbench

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_mult_seq_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier: one partial-product row per cycle, valid/ready on both sides.
// Optional macro APPROX_TRUNC_EN skips rows 0 and 1 (approximate product, shorter latency).
module mult_seq_ctrl #(
   parameter int WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p,
   output logic                 busy
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_ROW = CW'(WIDTH - 1);
`ifdef APPROX_TRUNC_EN
   localparam logic [CW-1:0] FIRST_ROW = CW'(2);
`else
   localparam logic [CW-1:0] FIRST_ROW = CW'(0);
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  x_q, x_d;
   logic [WIDTH-1:0]  y_q, y_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic [PW-1:0]     p_q, p_d;

   // Partial-product row: multiplicand gated by one multiplier bit, aligned to its weight.
   function automatic logic [PW-1:0] row_term(input logic [WIDTH-1:0] a,
                                              input logic             sel,
                                              input logic [CW-1:0]    sh);
      row_term = {{WIDTH{1'b0}}, (a & {WIDTH{sel}})} << sh;
   endfunction

   // Next-state, datapath and next-output logic.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d     = x;
               y_d     = y;
               acc_d   = {PW{1'b0}};
               cnt_d   = FIRST_ROW;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            acc_d = acc_q + row_term(x_q, y_q[cnt_q], cnt_q);
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_ROW) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next state so they change cleanly on the edge.
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d == RUN) || (state_d == DONE);
      if (state_d == DONE) begin
         p_d = acc_d;
      end else begin
         p_d = {PW{1'b0}};
      end
   end

   // State, operand, accumulator and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         x_q         <= {WIDTH{1'b0}};
         y_q         <= {WIDTH{1'b0}};
         acc_q       <= {PW{1'b0}};
         cnt_q       <= {CW{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         p_q         <= {PW{1'b0}};
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         p_q         <= p_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign p         = p_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl (WIDTH=6): vector table through a scoreboard plus stall and reset sequences.
module tb_mult_seq_ctrl;

   localparam int W = 6;
`ifdef APPROX_TRUNC_EN
   localparam int LAT = W - 2;
`else
   localparam int LAT = W;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    x;
   logic [W-1:0]    y;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  p;
   logic            busy;

   int total = 0;
   int bad   = 0;
   logic [2*W-1:0] sb[$];

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] exp_exact;
      logic [2*W-1:0] exp_approx;
   } vec_t;

   vec_t vecs[10];

   mult_seq_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [2*W-1:0] pick(input vec_t v);
`ifdef APPROX_TRUNC_EN
      pick = v.exp_approx;
`else
      pick = v.exp_exact;
`endif
   endfunction

   // Called at a negedge; returns at the negedge after the output handshake.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp_p, input int hold);
      int n;
      int k;
      bit seen;
      logic [2*W-1:0] p0;
      logic [2*W-1:0] want;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      x         = a;
      y         = b;
      out_ready = (hold == 0);
      sb.push_back(exp_p);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n <= LAT + 4) begin
         if (out_valid) begin
            seen = 1'b1;
         end else begin
            if (n == 1) begin
               check("busy_run", 32'(busy), 32'd1);
               check("in_ready_run", 32'(in_ready), 32'd0);
            end
            x = W'($urandom);
            y = W'($urandom);
            @(negedge clk);
            n++;
         end
      end
      check("latency", 32'(n), 32'(LAT));
      if (seen && hold > 0) begin
         p0 = p;
         for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            x = W'($urandom);
            y = W'($urandom);
            @(negedge clk);
            check("stall_p_stable", 32'(p), 32'(p0));
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      want = (sb.size() > 0) ? sb.pop_front() : {2*W{1'bx}};
      if (seen) begin
         check("product", 32'(p), 32'(want));
      end
      @(negedge clk);
      check("valid_one_cycle", 32'(out_valid), 32'd0);
      check("p_zero_idle", 32'(p), 32'd0);
      check("in_ready_back", 32'(in_ready), 32'd1);
      check("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      vecs[0] = '{a: 6'd13, b: 6'd11, exp_exact: 12'h08F, exp_approx: 12'h068};
      vecs[1] = '{a: 6'd63, b: 6'd63, exp_exact: 12'hF81, exp_approx: 12'hEC4};
      vecs[2] = '{a: 6'd0,  b: 6'd63, exp_exact: 12'h000, exp_approx: 12'h000};
      vecs[3] = '{a: 6'd63, b: 6'd0,  exp_exact: 12'h000, exp_approx: 12'h000};
      vecs[4] = '{a: 6'd5,  b: 6'd7,  exp_exact: 12'h023, exp_approx: 12'h014};
      vecs[5] = '{a: 6'd1,  b: 6'd1,  exp_exact: 12'h001, exp_approx: 12'h000};
      vecs[6] = '{a: 6'd42, b: 6'd21, exp_exact: 12'h372, exp_approx: 12'h348};
      vecs[7] = '{a: 6'd63, b: 6'd1,  exp_exact: 12'h03F, exp_approx: 12'h000};
      vecs[8] = '{a: 6'd32, b: 6'd32, exp_exact: 12'h400, exp_approx: 12'h400};
      vecs[9] = '{a: 6'd7,  b: 6'd2,  exp_exact: 12'h00E, exp_approx: 12'h000};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      x         = '0;
      y         = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_p", 32'(p), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].a, vecs[i].b, pick(vecs[i]), 0);
      end

      // Consumer stalls five cycles in DONE while new operands are offered.
      run_op(6'd13, 6'd11, pick(vecs[0]), 5);
      run_op(6'd42, 6'd21, pick(vecs[6]), 0);

      // Reset pulse in the third RUN cycle discards the operation.
      in_valid = 1'b1;
      x = 6'd63;
      y = 6'd63;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_p", 32'(p), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int spurious;
         spurious = 0;
         for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (out_valid) spurious++;
         end
         check("no_valid_after_rst", 32'(spurious), 32'd0);
      end
      run_op(6'd5, 6'd7, pick(vecs[4]), 0);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
